// File: rtl/branch_resolution_unit_pkg.sv
// rtl/branch_resolution_unit_pkg.sv - shared types and constants for the branch resolution unit
//
// Contents:
//   bru_state_t      : resolution FSM state {RUN, FLUSH}
//   inflight_entry_t : one in-flight prediction {pc, taken, target, history}
//   INSN_BYTES       : fall-through increment for a not-taken branch
//   PERF_SAT         : saturation value of the performance counters
//   sat_inc()        : saturating 16-bit increment
package branch_resolution_unit_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

    // Width of the history snapshot held in each entry; the top-level
    // HIST_W may not exceed this (narrower values are zero-extended).
    localparam int ENTRY_HIST_W = 8;

    localparam logic [31:0] INSN_BYTES = 32'd4;
    localparam logic [15:0] PERF_SAT   = 16'hFFFF;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic [31:0]             target;
        logic [ENTRY_HIST_W-1:0] history;
    } inflight_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == PERF_SAT) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/branch_resolution_unit_fifo.sv
// rtl/branch_resolution_unit_fifo.sv - in-order in-flight prediction buffer (branch_inflight_fifo)
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write wdata at the tail (caller guarantees !full or same-cycle pop)
//   pop           : retire the head entry (caller guarantees !empty)
//   clear         : drop every entry; overrides push and pop
//   head          : oldest entry, meaningful while !empty
//   full, empty   : occupancy flags derived from the entry counter
module branch_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - resolves predicted branches and trains the global-history predictor
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   pred_valid/taken/pc/target/history : decode-stage prediction to enqueue
//   resolve_valid, resolve_taken     : mem-stage outcome of the oldest in-flight branch
//   mispredict, redirect_pc          : registered one-cycle redirect request
//   upd_valid, upd_index, upd_taken  : registered one-cycle predictor training write
//   full, empty                      : in-flight queue occupancy
//   perf_branches, perf_mispredicts  : saturating event counters
//   error                            : sticky protocol-violation flag
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int HIST_W       = ENTRY_HIST_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [31:0]       pred_pc,
    input  logic [31:0]       pred_target,
    input  logic [HIST_W-1:0] pred_history,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    output logic [HIST_W-1:0] upd_index,
    output logic              upd_taken,
    output logic              full,
    output logic              empty,
    output logic [15:0]       perf_branches,
    output logic [15:0]       perf_mispredicts,
    output logic              error
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    bru_state_t      state;
    logic [FC_W-1:0] flush_cnt;
    logic [15:0]     br_cnt;
    logic [15:0]     mis_cnt;

    inflight_entry_t wentry;
    inflight_entry_t head;
    logic            fifo_full;
    logic            fifo_empty;

    logic pop;
    logic mismatch;
    logic push;
    logic err_now;

    assign pop      = resolve_valid & ~fifo_empty;
    assign mismatch = pop & (head.taken != resolve_taken);

    // A mispredicting pop makes any same-cycle push wrong-path, so it is
    // dropped; the clear below wipes the rest of the queue.
    assign push = pred_valid & (state == RUN) & (~fifo_full | pop) & ~mismatch;

    assign err_now = (resolve_valid & fifo_empty) | (pred_valid & fifo_full & ~pop);

    always_comb begin
        wentry         = '0;
        wentry.pc      = pred_pc;
        wentry.taken   = pred_taken;
        wentry.target  = pred_target;
        wentry.history = ENTRY_HIST_W'(pred_history);
    end

    branch_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(inflight_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (mismatch),
        .wdata (wentry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_index   <= '0;
            upd_taken   <= 1'b0;
            br_cnt      <= '0;
            mis_cnt     <= '0;
            error       <= 1'b0;
        end else begin
            mispredict <= mismatch;
            upd_valid  <= pop;
            upd_taken  <= pop & resolve_taken;
            upd_index  <= pop ? head.history[HIST_W-1:0] : '0;

            // Correct path is the direction the branch actually went.
            if (mismatch) begin
                redirect_pc <= resolve_taken ? head.target : head.pc + INSN_BYTES;
            end else begin
                redirect_pc <= '0;
            end

            if (pop) begin
                br_cnt <= sat_inc(br_cnt);
            end
            if (mismatch) begin
                mis_cnt <= sat_inc(mis_cnt);
            end
            if (err_now) begin
                error <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (mismatch) begin
                        state     <= FLUSH;
                        flush_cnt <= FC_W'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - FC_W'(1);
                    if (flush_cnt == FC_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    assign full             = fifo_full;
    assign empty            = fifo_empty;
    assign perf_branches    = br_cnt;
    assign perf_mispredicts = mis_cnt;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - self-checking bench for branch_resolution_unit
module tb_branch_resolution_unit;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] pred_target;
    logic [7:0]  pred_history;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic        upd_taken;
    logic        full;
    logic        empty;
    logic [15:0] perf_branches;
    logic [15:0] perf_mispredicts;
    logic        error;

    int total = 0;
    int bad   = 0;

    branch_resolution_unit #(
        .DEPTH        (4),
        .HIST_W       (8),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .pred_target      (pred_target),
        .pred_history     (pred_history),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .full             (full),
        .empty            (empty),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic        pt;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [7:0]  h;
        logic        rv;
        logic        rt;
        logic        mis;
        logic [31:0] rpc;
        logic        uv;
        logic [7:0]  ui;
        logic        ut;
        logic        emp;
        logic        ful;
        logic        err;
        logic [15:0] nbr;
        logic [15:0] nmis;
    } vec_t;

    typedef struct {
        logic [7:0] h;
        logic       t;
    } fifo_exp_t;

    vec_t      vecs [19];
    vec_t      expq [$];
    fifo_exp_t hq   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [7:0] h,
                         input logic rv, input logic rt);
        pred_valid    = pv;
        pred_taken    = pt;
        pred_pc       = pc;
        pred_target   = tgt;
        pred_history  = h;
        resolve_valid = rv;
        resolve_taken = rt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        fifo_exp_t fe;

        //        pv pt pc             tgt          h      rv rt  mis rpc    uv ui     ut emp ful err nbr nmis
        vecs[0]  = '{1, 1, 32'h100, 32'h140, 8'h5A, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,   32'h0,   8'h00, 1, 1,  0, 32'h0, 1, 8'h5A, 1, 1, 0, 0, 1, 0};
        vecs[2]  = '{1, 1, 32'h200, 32'h180, 8'h11, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 32'h0,   32'h0,   8'h00, 1, 0,  1, 32'h204, 1, 8'h11, 0, 1, 0, 0, 2, 1};
        vecs[4]  = '{1, 0, 32'h300, 32'h3F0, 8'h77, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 0, 2, 1};
        vecs[5]  = '{1, 0, 32'h304, 32'h3F0, 8'h78, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 0, 2, 1};
        vecs[6]  = '{1, 0, 32'h300, 32'h3F0, 8'h22, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 0, 2, 1};
        vecs[7]  = '{1, 1, 32'h310, 32'h500, 8'h23, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 0, 2, 1};
        vecs[8]  = '{1, 0, 32'h320, 32'h600, 8'h24, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 0, 2, 1};
        vecs[9]  = '{1, 1, 32'h330, 32'h700, 8'h25, 1, 1,  1, 32'h3F0, 1, 8'h22, 1, 1, 0, 0, 3, 2};
        vecs[10] = '{0, 0, 32'h0,   32'h0,   8'h00, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 0, 3, 2};
        vecs[11] = '{0, 0, 32'h0,   32'h0,   8'h00, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 0, 3, 2};
        vecs[12] = '{0, 0, 32'h0,   32'h0,   8'h00, 1, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 1, 3, 2};
        vecs[13] = '{1, 0, 32'h400, 32'h480, 8'h33, 0, 0,  0, 32'h0, 0, 8'h00, 0, 0, 0, 1, 3, 2};
        vecs[14] = '{0, 0, 32'h0,   32'h0,   8'h00, 1, 0,  0, 32'h0, 1, 8'h33, 0, 1, 0, 1, 4, 2};
        vecs[15] = '{1, 1, 32'hFFFFFFFC, 32'h10, 8'h44, 0, 0, 0, 32'h0, 0, 8'h00, 0, 0, 0, 1, 4, 2};
        vecs[16] = '{0, 0, 32'h0,   32'h0,   8'h00, 1, 0,  1, 32'h0, 1, 8'h44, 0, 1, 0, 1, 5, 3};
        vecs[17] = '{1, 1, 32'h500, 32'h540, 8'h55, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 1, 5, 3};
        vecs[18] = '{0, 0, 32'h0,   32'h0,   8'h00, 0, 0,  0, 32'h0, 0, 8'h00, 0, 1, 0, 1, 5, 3};

        rst = 1'b1;
        idle();
        #12;
        check("rst.mispredict", mispredict, 0);
        check("rst.redirect_pc", redirect_pc, 0);
        check("rst.upd_valid", upd_valid, 0);
        check("rst.upd_index", upd_index, 0);
        check("rst.full", full, 0);
        check("rst.empty", empty, 1);
        check("rst.perf_branches", perf_branches, 0);
        check("rst.perf_mispredicts", perf_mispredicts, 0);
        check("rst.error", error, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven directed sequence through a scoreboard queue.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].pt, vecs[i].pc, vecs[i].tgt, vecs[i].h, vecs[i].rv, vecs[i].rt);
            expq.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = expq.pop_front();
            check($sformatf("v%0d.mispredict", i), mispredict, e.mis);
            check($sformatf("v%0d.redirect_pc", i), redirect_pc, e.rpc);
            check($sformatf("v%0d.upd_valid", i), upd_valid, e.uv);
            check($sformatf("v%0d.upd_index", i), upd_index, e.ui);
            check($sformatf("v%0d.upd_taken", i), upd_taken, e.ut);
            check($sformatf("v%0d.empty", i), empty, e.emp);
            check($sformatf("v%0d.full", i), full, e.ful);
            check($sformatf("v%0d.error", i), error, e.err);
            check($sformatf("v%0d.perf_branches", i), perf_branches, e.nbr);
            check($sformatf("v%0d.perf_mispredicts", i), perf_mispredicts, e.nmis);
        end

        // Asynchronous reset with two entries queued.
        @(negedge clk);
        drive(1, 0, 32'h600, 32'h640, 8'h01, 0, 0);
        @(negedge clk);
        drive(1, 0, 32'h610, 32'h650, 8'h02, 0, 0);
        @(posedge clk);
        #1;
        check("rq.pre_empty", empty, 0);
        check("rq.pre_error", error, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rq.empty", empty, 1);
        check("rq.error", error, 0);
        check("rq.full", full, 0);
        check("rq.perf_branches", perf_branches, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Asynchronous reset while the mispredict pulse is up and in FLUSH.
        @(negedge clk);
        drive(1, 1, 32'h700, 32'h740, 8'h03, 0, 0);
        @(negedge clk);
        drive(1, 0, 32'h704, 32'h780, 8'h04, 1, 0);
        @(posedge clk);
        #1;
        check("rf.pre_mispredict", mispredict, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rf.mispredict", mispredict, 0);
        check("rf.redirect_pc", redirect_pc, 0);
        check("rf.upd_valid", upd_valid, 0);
        check("rf.empty", empty, 1);
        check("rf.perf_mispredicts", perf_mispredicts, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'h800, 32'h840, 8'h05, 0, 0);
        @(posedge clk);
        #1;
        check("rf.run_push_empty", empty, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 8'h0, 1, 0);
        @(posedge clk);
        #1;
        check("rf.drain_upd_index", upd_index, 8'h05);
        check("rf.drain_empty", empty, 1);
        check("rf.drain_mispredict", mispredict, 0);

        // Full boundary, dropped push and order across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, i[0], 32'h1000 + 32'(i * 16), 32'h2000, 8'(8'h40 + i), 0, 0);
            hq.push_back('{8'(8'h40 + i), i[0]});
            @(posedge clk);
            #1;
            check($sformatf("fl.full_after_%0d", i), full, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        drive(1, 1, 32'h1F00, 32'h2000, 8'hEE, 0, 0);
        @(posedge clk);
        #1;
        check("fl.drop_full", full, 1);
        check("fl.drop_error", error, 1);
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            fe = hq.pop_front();
            drive(1, i[0], 32'h1000 + 32'(i * 16), 32'h2000, 8'(8'h40 + i), 1, fe.t);
            hq.push_back('{8'(8'h40 + i), i[0]});
            @(posedge clk);
            #1;
            check($sformatf("fl.pp%0d_upd_index", i), upd_index, fe.h);
            check($sformatf("fl.pp%0d_upd_valid", i), upd_valid, 1);
            check($sformatf("fl.pp%0d_mispredict", i), mispredict, 0);
            check($sformatf("fl.pp%0d_full", i), full, 1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fe = hq.pop_front();
            drive(0, 0, 32'h0, 32'h0, 8'h0, 1, fe.t);
            @(posedge clk);
            #1;
            check($sformatf("fl.drain%0d_upd_index", i), upd_index, fe.h);
            check($sformatf("fl.drain%0d_upd_taken", i), upd_taken, fe.t);
        end
        check("fl.final_empty", empty, 1);
        check("fl.perf_branches", perf_branches, 9);

        // Mispredict counter saturation.
        @(negedge clk);
        idle();
        force dut.mis_cnt = 16'hFFFE;
        #1;
        check("sat.preload", perf_mispredicts, 16'hFFFE);
        release dut.mis_cnt;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            drive(1, 1, 32'h900, 32'h940, 8'h06, 0, 0);
            @(negedge clk);
            drive(0, 0, 32'h0, 32'h0, 8'h0, 1, 0);
            @(posedge clk);
            #1;
            check($sformatf("sat.r%0d_mispredict", r), mispredict, 1);
            check($sformatf("sat.r%0d_redirect", r), redirect_pc, 32'h904);
            check($sformatf("sat.r%0d_count", r), perf_mispredicts, 16'hFFFF);
            @(negedge clk);
            idle();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
